// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-requester arbiter in front of a single-port password RAM.
// Each granted access runs IDLE -> ISSUE -> WAIT -> DONE and ends with a one-cycle ack.
// All outputs are registered and computed from the next state.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between requesters
// (undefined: requester 1 always wins ties and no pointer register exists).
module ram_access_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req1,
  input  logic              req2,
  input  logic              we1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic              ack1,
  output logic              ack2,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                gnt_q, gnt_d;      // 0 = requester 1, 1 = requester 2
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                ack1_q, ack1_d;
  logic                ack2_q, ack2_d;
  logic                win2_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_q, last_d;    // 1 = requester 2 was served last

  // Requester 2 wins when alone, or on a tie when requester 1 was served last
  always_comb begin
    win2_c = req2 && (!req1 || !last_q);
  end
`else
  // Fixed priority: requester 2 wins only when requester 1 is idle
  always_comb begin
    win2_c = req2 && !req1;
  end
`endif

  // Next-state, transaction latch and registered-output computation
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    gnt_d         = gnt_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    rdata_d       = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          state_d       = ISSUE;
          gnt_d         = win2_c;
          we_d          = win2_c ? we2 : we1;
          ram_address_d = win2_c ? addr2 : addr1;
          ram_data_d    = win2_c ? wdata2 : wdata1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d        = win2_c;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        if (!we_q) rdata_d = ram_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ram_wren_d = (state_d == ISSUE) ? we_d : 1'b0;
    busy_d     = (state_d != IDLE);
    ack1_d     = (state_d == DONE) && !gnt_q;
    ack2_d     = (state_d == DONE) && gnt_q;
  end

  // State and output registers; reset discards any transaction in flight
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      gnt_q         <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      ack1_q        <= 1'b0;
      ack2_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      gnt_q         <= gnt_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      ack1_q        <= ack1_d;
      ack2_q        <= ack2_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q        <= last_d;
`endif
    end
  end

  assign ack1        = ack1_q;
  assign ack2        = ack2_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a synchronous RAM model.
module tb_ram_access_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        req1 = 1'b0, req2 = 1'b0, we1 = 1'b0, we2 = 1'b0;
  logic [2:0]  addr1 = '0, addr2 = '0;
  logic [15:0] wdata1 = '0, wdata2 = '0;
  logic        ack1, ack2, busy, ram_wren;
  logic [15:0] rdata, ram_data;
  logic [2:0]  ram_address;
  logic [15:0] ram_q = '0;
  logic [15:0] mem [8];

  int tests = 0;
  int fails = 0;

  ram_access_arbiter #(.ADDR_W(3), .DATA_W(16)) dut (
    .clock(clock), .rst(rst),
    .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
    .ack1(ack1), .ack2(ack2), .rdata(rdata), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-before-write
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int order [4];
    int cyc;
    int got;
    int busy_cnt;
    int ack_cnt;

    for (int i = 0; i < 8; i++) mem[i] = '0;
`ifdef ARB_ROUND_ROBIN_EN
    order = '{1, 2, 1, 2};
`else
    order = '{1, 1, 1, 1};
`endif

    // Reset values
    #2 rst = 1'b0;
    #1;
    check("rst_ack1", 32'(ack1), 0);
    check("rst_ack2", 32'(ack2), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wren", 32'(ram_wren), 0);
    check("rst_addr", 32'(ram_address), 0);
    check("rst_data", 32'(ram_data), 0);
    check("rst_rdata", 32'(rdata), 0);
    tick();
    rst = 1'b1;

    // Write A5A5 to entry 3 from requester 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd3; wdata1 = 16'hA5A5;
    tick();
    req1 = 1'b0;
    check("w_issue_wren", 32'(ram_wren), 1);
    check("w_issue_addr", 32'(ram_address), 3);
    check("w_issue_data", 32'(ram_data), 32'hA5A5);
    check("w_issue_busy", 32'(busy), 1);
    tick();
    check("w_wait_wren", 32'(ram_wren), 0);
    check("w_wait_addr", 32'(ram_address), 3);
    check("w_wait_ack1", 32'(ack1), 0);
    tick();
    check("w_done_ack1", 32'(ack1), 1);
    check("w_done_ack2", 32'(ack2), 0);
    tick();
    check("w_idle_ack1", 32'(ack1), 0);
    check("w_idle_busy", 32'(busy), 0);

    // Read entry 3 from requester 2
    req2 = 1'b1; we2 = 1'b0; addr2 = 3'd3;
    tick();
    req2 = 1'b0;
    check("r_issue_wren", 32'(ram_wren), 0);
    check("r_issue_addr", 32'(ram_address), 3);
    tick();
    tick();
    check("r_done_ack2", 32'(ack2), 1);
    check("r_done_ack1", 32'(ack1), 0);
    check("r_done_rdata", 32'(rdata), 32'hA5A5);
    tick();
    check("r_idle_ack2", 32'(ack2), 0);

    // Write 1234 to the top entry: rdata must keep its previous value
    req2 = 1'b1; we2 = 1'b1; addr2 = 3'd7; wdata2 = 16'h1234;
    tick();
    req2 = 1'b0;
    check("w7_issue_addr", 32'(ram_address), 7);
    tick();
    tick();
    check("w7_done_ack2", 32'(ack2), 1);
    check("w7_rdata_kept", 32'(rdata), 32'hA5A5);
    tick();

    // Reset so the tie pointer starts at "last = requester 2"
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Both requesters held high for four reads
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
    req2 = 1'b1; we2 = 1'b0; addr2 = 3'd7;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      got = 0;
      while (got == 0 && cyc < 10) begin
        tick();
        cyc++;
        check("tie_ack_excl", 32'(ack1 & ack2), 0);
        if (ack1 || ack2) got = 1;
      end
      check("tie_ack_seen", 32'(got), 1);
      check("tie_winner", ack2 ? 32'd2 : 32'd1, 32'(order[t]));
      check("tie_latency", 32'(cyc), (t == 0) ? 32'd3 : 32'd4);
      check("tie_rdata", 32'(rdata), (order[t] == 1) ? 32'hA5A5 : 32'h1234);
    end
    req1 = 1'b0; req2 = 1'b0;
    tick();
    tick();
    check("tie_idle_busy", 32'(busy), 0);

    // Reset during WAIT of a write aborts without ack
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'hBEEF;
    tick();
    req1 = 1'b0;
    tick();
    check("abort_in_wait", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort_wren", 32'(ram_wren), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_addr", 32'(ram_address), 0);
    tick();
    check("abort_ack1", 32'(ack1), 0);
    rst = 1'b1;
    tick();
    check("abort_no_ack", 32'(ack1 | ack2), 0);
    req2 = 1'b1; we2 = 1'b0; addr2 = 3'd3;
    tick();
    req2 = 1'b0;
    check("post_abort_busy", 32'(busy), 1);
    check("post_abort_addr", 32'(ram_address), 3);
    tick();
    tick();
    check("post_abort_ack2", 32'(ack2), 1);
    check("post_abort_rdata", 32'(rdata), 32'hA5A5);
    tick();

    // One-cycle request pulse still completes; busy lasts exactly 3 cycles
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd7;
    tick();
    req1 = 1'b0;
    busy_cnt = int'(busy);
    ack_cnt = int'(ack1);
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_cnt += int'(busy);
      ack_cnt += int'(ack1);
    end
    check("pulse_busy_cycles", 32'(busy_cnt), 3);
    check("pulse_ack1_count", 32'(ack_cnt), 1);
    check("pulse_rdata", 32'(rdata), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
